// File: rtl/axis_video_pattern_gen_if.sv
// AXI4-Stream video bus: one pixel per beat, tuser[0] marks start of frame, tlast marks end of line.
interface axis_video_pattern_gen_if #(
  parameter int WIDTH       = 48,
  parameter int TUSER_WIDTH = 1
) ();
  logic                   tvalid;
  logic                   tready;
  logic [WIDTH-1:0]       tdata;
  logic                   tlast;
  logic [TUSER_WIDTH-1:0] tuser;

  modport master (output tvalid, tdata, tlast, tuser, input tready);
  modport slave  (input tvalid, tdata, tlast, tuser, output tready);
endinterface

// File: rtl/axis_video_pattern_gen.sv
// AXI4-Stream video test-pattern source: full frames with SOF on tuser[0], EOL on tlast,
// backpressure-safe, with a programmable idle gap between frames.
module axis_video_pattern_gen #(
  parameter int          WIDTH       = 48,
  parameter int          TUSER_WIDTH = 1,
  parameter int unsigned H_ACTIVE    = 1920,
  parameter int unsigned V_ACTIVE    = 1080,
  parameter int unsigned FRAME_GAP   = 64
) (
  input  logic                     aclk,
  input  logic                     areset,
  input  logic                     enable,
  input  logic [1:0]               pattern_sel,
  axis_video_pattern_gen_if.master m_axis,
  output logic                     busy,
  output logic [31:0]              frame_cnt
);

  localparam int          C        = WIDTH / 3;
  localparam int unsigned BAR_PX   = (H_ACTIVE >= 8) ? H_ACTIVE / 8 : 1;
  localparam logic [15:0] X_LAST   = 16'(H_ACTIVE - 1);
  localparam logic [15:0] Y_LAST   = 16'(V_ACTIVE - 1);
  localparam logic [15:0] BAR_LAST = 16'(BAR_PX - 1);
  localparam logic [31:0] GAP_LAST = 32'(FRAME_GAP - 1);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACTIVE = 2'd1;
  localparam logic [1:0] GAP    = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [15:0]      x_q, x_d, y_q, y_d;
  logic [15:0]      bar_px_q, bar_px_d;
  logic [2:0]       bar_q, bar_d;
  logic [31:0]      gap_cnt_q, gap_cnt_d;
  logic [31:0]      frame_cnt_q, frame_cnt_d;
  logic [1:0]       sel_q, sel_d;
  logic [WIDTH-1:0] tdata_q, tdata_d;
  logic             tvalid_q, tvalid_d;
  logic             tlast_q, tlast_d;
  logic             tuser_q, tuser_d;
  logic             busy_q, busy_d;
  logic             beat;
  logic             start_frame;

  function automatic logic [WIDTH-1:0] pixel(input logic [1:0]  sel,
                                             input logic [15:0] x,
                                             input logic [15:0] y,
                                             input logic [2:0]  bar);
    logic [C-1:0]     c0, c1, c2;
    logic [WIDTH-1:0] p;
    c0 = '0;
    c1 = '0;
    c2 = '0;
    p  = '0;
    unique case (sel)
      2'd0: begin
        c0 = {C{bar[0]}};
        c1 = {C{bar[1]}};
        c2 = {C{bar[2]}};
      end
      2'd1: begin
        c0 = C'(x);
        c1 = c0;
        c2 = c0;
      end
      2'd2: begin
        c0 = {C{x[4] ^ y[4]}};
        c1 = c0;
        c2 = c0;
      end
      default: ;
    endcase
    p[3*C-1:0] = {c2, c1, c0};
    if (sel == 2'd3) p = WIDTH'({y, x});
    return p;
  endfunction

  always_comb begin
    // NOTE: every _d defaults to its _q first, so no branch can leave a signal unassigned and infer a latch.
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    bar_d       = bar_q;
    bar_px_d    = bar_px_q;
    gap_cnt_d   = gap_cnt_q;
    frame_cnt_d = frame_cnt_q;
    sel_d       = sel_q;
    start_frame = 1'b0;
    beat        = tvalid_q & m_axis.tready;

    unique case (state_q)
      IDLE: start_frame = enable;
      ACTIVE: begin
        if (beat) begin
          if (x_q == X_LAST) begin
            x_d      = '0;
            bar_d    = '0;
            bar_px_d = '0;
            if (y_q == Y_LAST) begin
              y_d         = '0;
              frame_cnt_d = frame_cnt_q + 32'd1;
              if (FRAME_GAP != 0) begin
                state_d   = GAP;
                gap_cnt_d = '0;
              end else if (enable) begin
                start_frame = 1'b1;
              end else begin
                state_d = IDLE;
              end
            end else begin
              y_d = y_q + 16'd1;
            end
          end else begin
            x_d = x_q + 16'd1;
            if (bar_px_q == BAR_LAST) begin
              bar_px_d = '0;
              bar_d    = bar_q + 3'd1;
            end else begin
              bar_px_d = bar_px_q + 16'd1;
            end
          end
        end
      end
      GAP: begin
        gap_cnt_d = gap_cnt_q + 32'd1;
        if (gap_cnt_q == GAP_LAST) begin
          if (enable) start_frame = 1'b1;
          else        state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // The pattern is latched only here, so mid-frame selector changes wait for the next frame.
    if (start_frame) begin
      state_d  = ACTIVE;
      x_d      = '0;
      y_d      = '0;
      bar_d    = '0;
      bar_px_d = '0;
      sel_d    = pattern_sel;
    end

    // Outputs are precomputed for the pixel that will be on the bus after this edge.
    tvalid_d = (state_d == ACTIVE);
    busy_d   = (state_d != IDLE);
    tlast_d  = tvalid_d && (x_d == X_LAST);
    tuser_d  = tvalid_d && (x_d == 16'd0) && (y_d == 16'd0);
    tdata_d  = tvalid_d ? pixel(sel_d, x_d, y_d, bar_d) : '0;
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q     <= IDLE;
      x_q         <= '0;
      y_q         <= '0;
      bar_q       <= '0;
      bar_px_q    <= '0;
      gap_cnt_q   <= '0;
      frame_cnt_q <= '0;
      sel_q       <= '0;
      tdata_q     <= '0;
      tvalid_q    <= 1'b0;
      tlast_q     <= 1'b0;
      tuser_q     <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge values of the others.
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      bar_q       <= bar_d;
      bar_px_q    <= bar_px_d;
      gap_cnt_q   <= gap_cnt_d;
      frame_cnt_q <= frame_cnt_d;
      sel_q       <= sel_d;
      tdata_q     <= tdata_d;
      tvalid_q    <= tvalid_d;
      tlast_q     <= tlast_d;
      tuser_q     <= tuser_d;
      busy_q      <= busy_d;
    end
  end

  assign m_axis.tvalid = tvalid_q;
  assign m_axis.tdata  = tdata_q;
  assign m_axis.tlast  = tlast_q;
  assign m_axis.tuser  = TUSER_WIDTH'(tuser_q);
  assign busy          = busy_q;
  assign frame_cnt     = frame_cnt_q;

endmodule

// File: doc/axis_video_pattern_gen.md
# axis_video_pattern_gen

AXI4-Stream video test-pattern source that sits directly upstream of the passthrough monitor and drives its slave port. It emits complete frames of H_ACTIVE × V_ACTIVE pixels with start-of-frame on tuser[0] and end-of-line on tlast, fully honouring downstream backpressure. A programmable inter-frame gap lets the monitor's fps and line/column counters be checked against known values.

## Interface
- WIDTH, 48, tdata width; component width C = WIDTH/3 (integer), unused MSBs driven 0
- TUSER_WIDTH, 1, tuser width; only bit 0 used, others driven 0
- H_ACTIVE, 1920, pixels per line (1..65535, multiple of 8)
- V_ACTIVE, 1080, lines per frame (1..65535)
- FRAME_GAP, 64, idle cycles between frames (0..2^32-1)
- aclk  in  1  sole clock, all logic on rising edge
- areset  in  1  synchronous, active-high reset
- enable  in  1  run request; sampled at frame boundaries
- pattern_sel  in  2  0 colour bars, 1 ramp, 2 checkerboard, 3 coordinate counter
- m_axis_tvalid  out  1  beat valid
- m_axis_tready  in  1  downstream ready
- m_axis_tdata  out  WIDTH  pixel {c2,c1,c0}, c0 in LSBs
- m_axis_tlast  out  1  last pixel of line
- m_axis_tuser  out  TUSER_WIDTH  bit 0 = first pixel of frame
- busy  out  1  high in ACTIVE or GAP
- frame_cnt  out  32  completed frames, wraps at 2^32

## Operation
- States: IDLE, ACTIVE, GAP. Counters x, y (16 bit), gap_cnt (32 bit), bar index (3 bit), bar pixel counter.
- IDLE: tvalid=0. enable=1 → ACTIVE next cycle with x=y=0; pattern_sel latched on that transition and held for the whole frame.
- ACTIVE: tvalid=1. Beat = tvalid & tready. On beat: x+1; at x=H_ACTIVE-1, x→0, y+1. No beat → all outputs hold (AXIS stability rule; tdata/tlast/tuser never change while tvalid=1 and tready=0).
- tlast=1 iff x=H_ACTIVE-1. tuser[0]=1 iff x=0 and y=0.
- Last beat of frame (x=H_ACTIVE-1, y=V_ACTIVE-1): frame_cnt+1; then FRAME_GAP>0 → GAP (gap_cnt=0); FRAME_GAP=0 → ACTIVE (enable=1) or IDLE (enable=0), no bubble.
- GAP: tvalid=0 for exactly FRAME_GAP cycles; on final gap cycle go ACTIVE if enable=1 else IDLE.
- enable deasserted mid-frame: frame always completes; never truncated.
- Patterns (component value, C bits):
  - 0 bars: 8 bars of H_ACTIVE/8 px; bar index b (0..7) resets each line; c2=b[2],c1=b[1],c0=b[0], each bit replicated to all-ones/zero. Bar 0 black, bar 7 white.
  - 1 ramp: c0=c1=c2=x[C-1:0] (zero-extended if C>16).
  - 2 checker: all components all-ones if x[4]^y[4], else 0.
  - 3 coordinate: tdata = {y,x} zero-extended/truncated to WIDTH.
- pattern_sel changes mid-frame have no effect until next frame start.

## Timing
- Reset values: tvalid 0, tlast 0, tuser 0, tdata 0, busy 0, frame_cnt 0, state IDLE; all outputs registered.
- areset mid-frame: next cycle tvalid=0, counters zeroed, frame abandoned; frame_cnt not incremented.
- enable high at edge N in IDLE → first beat presented (tvalid=1, tuser[0]=1) at edge N+1.
- With tready held 1: line = H_ACTIVE consecutive beats; frame period = H_ACTIVE·V_ACTIVE + FRAME_GAP cycles.
- Handshake: next beat data valid on the cycle after a beat; zero-bubble throughput at tready=1.
- frame_cnt updates on the edge of the frame's last beat; wraps 0xFFFFFFFF→0.
- H_ACTIVE=1: every beat has tlast=1; V_ACTIVE=1: tuser and last-of-frame on same line.

## Test plan
- H=8,V=4,GAP=3,sel=3, tready=1, enable=1 -> 32 beats, tdata 0x0000..0x0007,0x10000..0x30007, tuser only on beat 0, tlast on beats 7,15,23,31, then 3 cycles tvalid=0, frame_cnt=1, next tuser.
- Same config, tready random 50% -> tdata/tlast/tuser stable while stalled, identical beat sequence, frame_cnt=1 after 32 beats.
- H=16,V=2,sel=0,WIDTH=48 -> pixels 0-1 tdata 0, pixels 2-3 0x000000000000FFFF, pixels 14-15 0xFFFFFFFFFFFF; bar index restarts line 1.
- GAP=0, enable=1 for 3 frames then drop in frame 3 -> back-to-back frames, no tvalid gap, frame 3 completes, then IDLE, busy=0, frame_cnt=3.
- areset pulse at beat 10 of frame -> tvalid=0 next cycle, frame_cnt=0; after release with enable=1 new frame starts at x=y=0 with tuser=1.
- sel changed 1→2 mid-frame -> remainder of frame stays ramp; next frame checkerboard.
